cache_ctrl: RTL and testbench

Set-associative cache controller sitting directly upstream of the cache data array. It accepts single-word processor read/write requests, holds the tag and valid arrays internally, and decides hit/miss. It drives the data array's way/index/write port and services misses and write-throughs over a simple req/ack memory port. Policy is write-through, no-write-allocate, with per-set round-robin replacement and one word per line.

---
 rtl/cache_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate set-associative cache controller.
// Holds tags/valids, drives the external data array, and services misses over a req/ack memory port.
module cache_ctrl #(
    parameter int  WIDTH      = 8,
    parameter int  WAYS       = 4,
    parameter int  TOTAL_SIZE = 16,
    parameter int  ADDR_WIDTH = 8,
    localparam int SETS       = TOTAL_SIZE / WAYS,
    localparam int IDX        = $clog2(SETS),
    localparam int WAY_W      = $clog2(WAYS),
    localparam int TAG_W      = ADDR_WIDTH - IDX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  dat_we,
    output logic                  dat_re,
    output logic [WAY_W-1:0]      dat_way,
    output logic [IDX-1:0]        dat_index,
    output logic [WIDTH-1:0]      dat_wdata,
    input  logic [WAYS*WIDTH-1:0] dat_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [WIDTH-1:0]        wdata_r;
    logic [WIDTH-1:0]        fill_r;
    logic                    hit_r;

    logic [TAG_W-1:0]        tag_r [WAYS][SETS];
    logic [WAYS-1:0]         valid_r [SETS];
    logic [WAY_W-1:0]        rr_ptr_r [SETS];

    logic [IDX-1:0]          idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [WAYS-1:0]         match_s;
    logic [WAYS-1:0]         free_s;
    logic                    hit_s;
    logic                    all_valid_s;
    logic [WAY_W-1:0]        hit_way_s;
    logic [WAY_W-1:0]        victim_s;
    logic [WIDTH-1:0]        hit_data_s;
    logic                    resp_hit_s;
    logic [WIDTH-1:0]        resp_rdata_s;
    logic                    resp_valid_r;
    logic                    resp_hit_r;
    logic [WIDTH-1:0]        resp_rdata_r;

    assign idx_s      = addr_r[IDX-1:0];
    assign tag_s      = addr_r[ADDR_WIDTH-1:IDX];
    assign dat_index  = idx_s;
    assign req_ready  = (state_r == S_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_rdata = resp_rdata_r;

    // Tag compare and victim choice; the descending scan makes the lowest way win both.
    always_comb begin
        match_s     = '0;
        free_s      = ~valid_r[idx_s];
        all_valid_s = &valid_r[idx_s];
        hit_way_s   = '0;
        victim_s    = rr_ptr_r[idx_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_s[w] = valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s);
            hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
            victim_s   = free_s[w] ? WAY_W'(w) : victim_s;
        end
        hit_s      = |match_s;
        hit_data_s = dat_rdata[hit_way_s*WIDTH +: WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) state_s = S_LOOKUP;
                else           state_s = S_IDLE;
            end
            S_LOOKUP: begin
                if (we_r)       state_s = S_MEM_WR;
                else if (hit_s) state_s = S_RESP;
                else            state_s = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ack) state_s = S_FILL;
                else         state_s = S_MEM_RD;
            end
            S_FILL:   state_s = S_RESP;
            S_MEM_WR: begin
                if (mem_ack) state_s = S_RESP;
                else         state_s = S_MEM_WR;
            end
            S_RESP:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Per-state decode of the array and memory ports, plus the response about to be registered.
    always_comb begin
        dat_we       = 1'b0;
        dat_re       = 1'b0;
        dat_way      = '0;
        dat_wdata    = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        resp_hit_s   = 1'b0;
        resp_rdata_s = '0;
        case (state_r)
            S_LOOKUP: begin
                dat_re       = 1'b1;
                dat_way      = hit_way_s;
                resp_hit_s   = hit_s;
                resp_rdata_s = hit_data_s;
                if (we_r && hit_s) begin
                    dat_we    = 1'b1;
                    dat_wdata = wdata_r;
                end else begin
                    dat_we    = 1'b0;
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = addr_r;
            end
            S_FILL: begin
                dat_we       = 1'b1;
                dat_way      = victim_s;
                dat_wdata    = fill_r;
                resp_rdata_s = fill_r;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = addr_r;
                mem_wdata  = wdata_r;
                resp_hit_s = hit_r;
            end
            default: begin
                dat_we = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_IDLE;
        else      state_r <= state_s;
    end

    // Latched request fields, write-hit flag and fill data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            fill_r  <= '0;
            hit_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        we_r    <= req_we;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                    end
                end
                S_LOOKUP: hit_r <= hit_s;
                S_MEM_RD: begin
                    if (mem_ack) fill_r <= mem_rdata;
                end
                default: hit_r <= hit_r;
            endcase
        end
    end

    // Tag, valid and round-robin state; only a fill modifies them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s]  <= '0;
                rr_ptr_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) tag_r[w][s] <= '0;
            end
        end else if (state_r == S_FILL) begin
            tag_r[victim_s][idx_s]   <= tag_s;
            valid_r[idx_s][victim_s] <= 1'b1;
            if (all_valid_s) rr_ptr_r[idx_s] <= rr_ptr_r[idx_s] + WAY_W'(1);
        end
    end

    // Registered response, loaded on the edge that enters RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else if (state_s == S_RESP) begin
            resp_valid_r <= 1'b1;
            resp_hit_r   <= resp_hit_s;
            resp_rdata_r <= resp_rdata_s;
        end else begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_rdata_r <= '0;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: data array and backing memory are modelled here,
// expected responses go through a scoreboard queue.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic        resp_hit;
    logic [7:0]  resp_rdata;
    logic        dat_we;
    logic        dat_re;
    logic [1:0]  dat_way;
    logic [1:0]  dat_index;
    logic [7:0]  dat_wdata;
    logic [31:0] dat_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int          checks;
    int          errors;
    logic [7:0]  mem_model [256];
    logic [7:0]  arr [4][4];
    logic [8:0]  sb [$];

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .dat_we(dat_we), .dat_re(dat_re), .dat_way(dat_way), .dat_index(dat_index),
        .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data array storage: written on the clock, read combinationally at dat_index.
    always_ff @(posedge clk) begin
        if (dat_we) arr[dat_way][dat_index] <= dat_wdata;
    end

    // Present all ways at the current index.
    always_comb begin
        dat_rdata = '0;
        for (int w = 0; w < 4; w++) dat_rdata[w*8 +: 8] = arr[w][dat_index];
    end

    // One request; memory acks in its ack_lat-th request cycle; response checked against scoreboard.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input int ack_lat, input logic exp_hit, input logic exp_mem,
                          input string name);
        int         mcyc;
        int         lat_exp;
        logic       got;
        logic       ready_bad;
        logic       unstable;
        logic [8:0] exp;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_ready: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        lat_exp   = we ? ack_lat + 2 : (exp_hit ? 2 : ack_lat + 3);
        sb.push_back({exp_hit, (we ? 8'h00 : mem_model[addr])});
        if (we) mem_model[addr] = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        mcyc      = 0;
        got       = 1'b0;
        ready_bad = 1'b0;
        unstable  = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (req_ready) ready_bad = 1'b1;
            if (mem_req) begin
                mcyc++;
                if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata))
                    unstable = 1'b1;
                if (mcyc == ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = we ? 8'h00 : mem_model[addr];
                end
            end
            if (resp_valid) begin
                got = 1'b1;
                exp = sb.pop_front();
                checks++;
                if (resp_hit !== exp[8]) begin
                    errors++;
                    $display("FAIL %s hit: got %b want %b", name, resp_hit, exp[8]);
                end
                checks++;
                if (resp_rdata !== exp[7:0]) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", name, resp_rdata, exp[7:0]);
                end
                checks++;
                if (n != lat_exp) begin
                    errors++;
                    $display("FAIL %s latency: got %0d want %0d", name, n, lat_exp);
                end
            end
        end
        mem_ack = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no resp_valid within 40 cycles", name);
            if (sb.size() > 0) exp = sb.pop_front();
        end
        checks++;
        if (ready_bad !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_ready: got 1 want 0", name);
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL %s mem_fields: addr/we/wdata wrong while mem_req high", name);
        end
        checks++;
        if (mcyc != (exp_mem ? ack_lat : 0)) begin
            errors++;
            $display("FAIL %s mem_cycles: got %0d want %0d", name, mcyc, exp_mem ? ack_lat : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_hit, resp_rdata} !== 10'h000) begin
            errors++;
            $display("FAIL reset_resp: got %b%b%h want 0", resp_valid, resp_hit, resp_rdata);
        end
        checks++;
        if ({dat_we, dat_re, mem_req, mem_we, mem_addr, mem_wdata} !== 20'h00000) begin
            errors++;
            $display("FAIL reset_ports: got we%b re%b req%b mwe%b a%h d%h want 0",
                     dat_we, dat_re, mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_cold_read();
        do_req(1'b0, 8'h05, 8'h00, 3, 1'b0, 1'b1, "cold_miss");
        do_req(1'b0, 8'h05, 8'h00, 0, 1'b1, 1'b0, "cold_hit");
    endtask

    task automatic test_write_hit();
        do_req(1'b1, 8'h05, 8'h3C, 2, 1'b1, 1'b1, "wr_hit");
        do_req(1'b0, 8'h05, 8'h00, 0, 1'b1, 1'b0, "wr_hit_reread");
    endtask

    task automatic test_write_miss();
        do_req(1'b1, 8'h22, 8'h7E, 1, 1'b0, 1'b1, "wr_miss");
        do_req(1'b0, 8'h22, 8'h00, 2, 1'b0, 1'b1, "wr_miss_reread");
    endtask

    task automatic test_replacement();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 8'h01, 8'h00, 1, 1'b0, 1'b1, "fill_w0");
        do_req(1'b0, 8'h05, 8'h00, 1, 1'b0, 1'b1, "fill_w1");
        do_req(1'b0, 8'h09, 8'h00, 1, 1'b0, 1'b1, "fill_w2");
        do_req(1'b0, 8'h0D, 8'h00, 1, 1'b0, 1'b1, "fill_w3");
        do_req(1'b0, 8'h11, 8'h00, 1, 1'b0, 1'b1, "evict_w0");
        do_req(1'b0, 8'h01, 8'h00, 1, 1'b0, 1'b1, "evict_w1");
        do_req(1'b0, 8'h09, 8'h00, 0, 1'b1, 1'b0, "keep_09");
        do_req(1'b0, 8'h05, 8'h00, 1, 1'b0, 1'b1, "evict_w2");
        do_req(1'b0, 8'h0D, 8'h00, 0, 1'b1, 1'b0, "keep_0d");
        do_req(1'b0, 8'h11, 8'h00, 0, 1'b1, 1'b0, "keep_11");
    endtask

    task automatic test_slow_mem();
        do_req(1'b0, 8'h30, 8'h00, 6, 1'b0, 1'b1, "slow_mem");
    endtask

    task automatic test_reset_mid_miss();
        int seen;
        do_req(1'b0, 8'h09, 8'h00, 2, 1'b0, 1'b1, "prep_09_miss");
        do_req(1'b0, 8'h09, 8'h00, 0, 1'b1, 1'b0, "prep_09_hit");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h33;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_mem_req_up: got %b want 1", mem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_mem_req_drop: got %b want 0", mem_req);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_req) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d resp/mem cycles want 0", seen);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b want 1", req_ready);
        end
        do_req(1'b0, 8'h09, 8'h00, 2, 1'b0, 1'b1, "after_abort_09");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'hA0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cold_read();
        test_write_hit();
        test_write_miss();
        test_replacement();
        test_slow_mem();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
